plic_arbiter: RTL and testbench

PLIC_ARBITER -- requirements
Module: plic_arbiter

---
 rtl/plic_arbiter_if.sv | 12 +
 rtl/plic_arbiter.sv | 130 +++++++++++++
 tb/tb_plic_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/plic_arbiter_if.sv
// Register access bus of the PLIC arbiter: one strobe per cycle and read data
// that is registered one cycle after the strobe.
interface plic_arbiter_if;
   logic        reg_en;
   logic        reg_we;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;

   modport master (output reg_en, output reg_we, output reg_addr, output reg_wdata, input reg_rdata);
   modport slave  (input reg_en, input reg_we, input reg_addr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/plic_arbiter.sv
// PLIC-style interrupt arbiter: per-source priority/enable, threshold, registered
// winner selection and claim/complete pulses toward the gateways.
module plic_arbiter #(
   parameter int NSRC   = 8,
   parameter int PRIO_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NSRC-1:0]   ip,
   output logic [NSRC-1:0]   claim,
   output logic [NSRC-1:0]   complete,
   plic_arbiter_if.slave     bus,
   output logic              eip
);

   localparam int ID_W = $clog2(NSRC + 1);

   logic [PRIO_W-1:0] prio_q [NSRC];
   logic [PRIO_W-1:0] prio_d [NSRC];
   logic [NSRC-1:0]   enable_q, enable_d;
   logic [PRIO_W-1:0] thr_q, thr_d;
   logic [ID_W-1:0]   best_id_q, best_id_d;
   logic [PRIO_W-1:0] best_prio_q, best_prio_d;
   logic              eip_q, eip_d;
   logic [NSRC-1:0]   claim_q, claim_d;
   logic [NSRC-1:0]   complete_q, complete_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [5:0]        widx_s;
   logic [31:0]       rd_val_s;
   logic              take_s;
   logic              unused_ok_s;

   assign widx_s      = bus.reg_addr[7:2];
   assign unused_ok_s = ^{bus.reg_wdata, bus.reg_addr[1:0]};

   // Winner search: strict '>' keeps the lowest ID on ties and excludes priority 0.
   always_comb begin
      best_id_d   = '0;
      best_prio_d = '0;
      take_s      = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         take_s      = ip[i] && enable_q[i] && (prio_q[i] > best_prio_d);
         best_id_d   = take_s ? ID_W'(i + 1) : best_id_d;
         best_prio_d = take_s ? prio_q[i] : best_prio_d;
      end
      eip_d = (best_prio_q > thr_q);
   end

   // Read-data multiplexer over the register map.
   always_comb begin
      rd_val_s = 32'd0;
      case (widx_s)
         6'h10:   rd_val_s = 32'({enable_q, 1'b0});
         6'h11:   rd_val_s = 32'(thr_q);
         6'h12:   rd_val_s = 32'(best_id_q);
         6'h13:   rd_val_s = 32'({ip, 1'b0});
         default: begin
            for (int i = 0; i < NSRC; i++) begin
               rd_val_s = (widx_s == 6'(i + 1)) ? 32'(prio_q[i]) : rd_val_s;
            end
         end
      endcase
   end

   // Register writes, read capture and claim/complete pulse generation.
   always_comb begin
      prio_d     = prio_q;
      enable_d   = enable_q;
      thr_d      = thr_q;
      rdata_d    = rdata_q;
      claim_d    = '0;
      complete_d = '0;
      if (bus.reg_en && bus.reg_we) begin
         case (widx_s)
            6'h10:   enable_d = bus.reg_wdata[NSRC:1];
            6'h11:   thr_d = bus.reg_wdata[PRIO_W-1:0];
            6'h12: begin
               for (int i = 0; i < NSRC; i++) begin
                  complete_d[i] = (bus.reg_wdata[7:0] == 8'(i + 1)) && enable_q[i];
               end
            end
            default: begin
               for (int i = 0; i < NSRC; i++) begin
                  prio_d[i] = (widx_s == 6'(i + 1)) ? bus.reg_wdata[PRIO_W-1:0] : prio_q[i];
               end
            end
         endcase
      end else if (bus.reg_en) begin
         rdata_d = rd_val_s;
         for (int i = 0; i < NSRC; i++) begin
            claim_d[i] = (widx_s == 6'h12) && (best_id_q == ID_W'(i + 1));
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers; reset also cancels any pulse in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSRC; i++) begin
            prio_q[i] <= '0;
         end
         enable_q    <= '0;
         thr_q       <= '0;
         best_id_q   <= '0;
         best_prio_q <= '0;
         eip_q       <= 1'b0;
         claim_q     <= '0;
         complete_q  <= '0;
         rdata_q     <= 32'd0;
      end else begin
         prio_q      <= prio_d;
         enable_q    <= enable_d;
         thr_q       <= thr_d;
         best_id_q   <= best_id_d;
         best_prio_q <= best_prio_d;
         eip_q       <= eip_d;
         claim_q     <= claim_d;
         complete_q  <= complete_d;
         rdata_q     <= rdata_d;
      end
   end

   assign claim         = claim_q;
   assign complete      = complete_q;
   assign eip           = eip_q;
   assign bus.reg_rdata = rdata_q;

endmodule

// File: tb/tb_plic_arbiter.sv
// Directed table-driven bench for plic_arbiter (NSRC=8, PRIO_W=3) plus
// hand-written latency, pulse-width and reset-during-claim sequences.
module tb_plic_arbiter;

   localparam int OP_W = 0;
   localparam int OP_R = 1;
   localparam int OP_I = 2;

   typedef struct {
      int          op;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  ipv;
      logic [31:0] exp;
      logic [7:0]  exp_claim;
      logic [7:0]  exp_cmp;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] ip;
   logic [7:0] claim;
   logic [7:0] complete;
   logic       eip;
   int         n_vec;
   int         n_err;
   vec_t       tbl[$];

   plic_arbiter_if bus_if ();

   plic_arbiter #(.NSRC(8), .PRIO_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ip       (ip),
      .claim    (claim),
      .complete (complete),
      .bus      (bus_if),
      .eip      (eip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One-cycle strobe driven on the falling edge; returns on the next falling edge.
   task automatic acc(input logic we, input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.reg_en    = 1'b1;
      bus_if.reg_we    = we;
      bus_if.reg_addr  = a;
      bus_if.reg_wdata = d;
      @(negedge clk);
      bus_if.reg_en    = 1'b0;
      bus_if.reg_we    = 1'b0;
   endtask

   function automatic void add(input int op, input logic [7:0] a, input logic [31:0] d,
                               input logic [7:0] ipv, input logic [31:0] e,
                               input logic [7:0] c, input logic [7:0] cp);
      tbl.push_back('{op, a, d, ipv, e, c, cp});
   endfunction

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      ip = 8'h00;
      bus_if.reg_en = 1'b0;
      bus_if.reg_we = 1'b0;
      bus_if.reg_addr = 8'h00;
      bus_if.reg_wdata = 32'd0;

      //  op    addr   wdata         ip     exp        claim  complete
      add(OP_W, 8'h0C, 32'd5,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h18, 32'd5,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h40, 32'h48,       8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h44, 32'd2,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_I, 8'h00, 32'd0,        8'h24, 32'd1,     8'h00, 8'h00);
      add(OP_R, 8'h48, 32'd0,        8'h24, 32'd3,     8'h04, 8'h00);
      add(OP_W, 8'h44, 32'd5,        8'h24, 32'd0,     8'h00, 8'h00);
      add(OP_I, 8'h00, 32'd0,        8'h24, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h44, 32'd4,        8'h24, 32'd0,     8'h00, 8'h00);
      add(OP_I, 8'h00, 32'd0,        8'h24, 32'd1,     8'h00, 8'h00);
      add(OP_R, 8'h44, 32'd0,        8'h24, 32'd4,     8'h00, 8'h00);
      add(OP_R, 8'h40, 32'd0,        8'h24, 32'h48,    8'h00, 8'h00);
      add(OP_R, 8'h0C, 32'd0,        8'h24, 32'd5,     8'h00, 8'h00);
      add(OP_I, 8'h00, 32'd0,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h48, 32'd0,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h48, 32'd9,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h48, 32'd0,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h48, 32'd3,        8'h00, 32'd0,     8'h00, 8'h04);
      add(OP_W, 8'h40, 32'h04,       8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h48, 32'd2,        8'h00, 32'd0,     8'h00, 8'h02);
      add(OP_W, 8'h40, 32'h00,       8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h48, 32'd2,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h10, 32'hFF,       8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h10, 32'd0,        8'h00, 32'd7,     8'h00, 8'h00);
      add(OP_W, 8'h00, 32'hFFFF,     8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h00, 32'd0,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h50, 32'd0,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h4C, 32'd0,        8'h81, 32'h102,   8'h00, 8'h00);
      add(OP_W, 8'h40, 32'hFFFFFFFF, 8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h40, 32'd0,        8'h00, 32'h1FE,   8'h00, 8'h00);
      add(OP_W, 8'h24, 32'd7,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h24, 32'd0,        8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h48, 32'd0,        8'h24, 32'd3,     8'h04, 8'h00);
      add(OP_R, 8'h48, 32'd0,        8'h2C, 32'd4,     8'h08, 8'h00);
      add(OP_R, 8'h48, 32'd0,        8'h20, 32'd6,     8'h20, 8'h00);
      add(OP_R, 8'h48, 32'd0,        8'h01, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h44, 32'd7,        8'h08, 32'd0,     8'h00, 8'h00);
      add(OP_I, 8'h00, 32'd0,        8'h08, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h44, 32'd0,        8'h01, 32'd0,     8'h00, 8'h00);
      add(OP_W, 8'h04, 32'd1,        8'h01, 32'd0,     8'h00, 8'h00);
      add(OP_I, 8'h00, 32'd0,        8'h01, 32'd1,     8'h00, 8'h00);
      add(OP_R, 8'h48, 32'd0,        8'h01, 32'd1,     8'h01, 8'h00);
      add(OP_W, 8'h44, 32'hFFFFFFFC, 8'h00, 32'd0,     8'h00, 8'h00);
      add(OP_R, 8'h44, 32'd0,        8'h00, 32'd4,     8'h00, 8'h00);

      repeat (3) @(negedge clk);
      check("rst_rdata", bus_if.reg_rdata, 32'd0);
      check("rst_claim", 32'(claim), 32'd0);
      check("rst_complete", 32'(complete), 32'd0);
      check("rst_eip", 32'(eip), 32'd0);
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         ip = tbl[k].ipv;
         if (tbl[k].op == OP_I) begin
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_eip", k), 32'(eip), tbl[k].exp);
         end else begin
            acc(tbl[k].op == OP_W, tbl[k].addr, tbl[k].wdata);
            if (tbl[k].op == OP_R) begin
               check($sformatf("v%0d_rdata", k), bus_if.reg_rdata, tbl[k].exp);
            end
            check($sformatf("v%0d_claim", k), 32'(claim), 32'(tbl[k].exp_claim));
            check($sformatf("v%0d_complete", k), 32'(complete), 32'(tbl[k].exp_cmp));
         end
      end

      // eip latency: best_id one edge after ip, eip one edge after that.
      @(negedge clk);
      ip = 8'h00;
      repeat (3) @(negedge clk);
      check("lat_eip_idle", 32'(eip), 32'd0);
      ip = 8'h08;
      @(negedge clk);
      check("lat_eip_early", 32'(eip), 32'd0);
      @(negedge clk);
      check("lat_eip_set", 32'(eip), 32'd1);

      // Claim pulse lasts one cycle; rdata holds across a following write.
      acc(1'b0, 8'h48, 32'd0);
      check("pulse_rdata", bus_if.reg_rdata, 32'd4);
      check("pulse_claim", 32'(claim), 32'h08);
      @(negedge clk);
      check("pulse_claim_gone", 32'(claim), 32'd0);
      acc(1'b1, 8'h44, 32'd5);
      check("hold_rdata", bus_if.reg_rdata, 32'd4);

      // Reset while the claim of ID4 is in flight.
      @(negedge clk);
      ip = 8'h08;
      bus_if.reg_en   = 1'b1;
      bus_if.reg_we   = 1'b0;
      bus_if.reg_addr = 8'h48;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus_if.reg_en = 1'b0;
      #1;
      check("rstc_claim", 32'(claim), 32'd0);
      check("rstc_rdata", bus_if.reg_rdata, 32'd0);
      check("rstc_eip", 32'(eip), 32'd0);
      repeat (2) @(negedge clk);
      check("rstc_claim_held", 32'(claim), 32'd0);
      // First access accepted on the first edge after release.
      rst_n = 1'b1;
      bus_if.reg_en    = 1'b1;
      bus_if.reg_we    = 1'b1;
      bus_if.reg_addr  = 8'h44;
      bus_if.reg_wdata = 32'd3;
      @(negedge clk);
      bus_if.reg_en = 1'b0;
      bus_if.reg_we = 1'b0;
      check("post_claim", 32'(claim), 32'd0);
      acc(1'b0, 8'h10, 32'd0);
      check("post_prio4", bus_if.reg_rdata, 32'd0);
      acc(1'b0, 8'h0C, 32'd0);
      check("post_prio3", bus_if.reg_rdata, 32'd0);
      acc(1'b0, 8'h40, 32'd0);
      check("post_enable", bus_if.reg_rdata, 32'd0);
      acc(1'b0, 8'h48, 32'd0);
      check("post_claimreg", bus_if.reg_rdata, 32'd0);
      check("post_claim2", 32'(claim), 32'd0);
      acc(1'b0, 8'h44, 32'd0);
      check("post_thr_first", bus_if.reg_rdata, 32'd3);
      check("post_eip", 32'(eip), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
